tristate_bus_arbiter: RTL

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

---
 rtl/tristate_bus_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/tristate_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tristate_bus_arbiter
// Brief    : Round-robin owner selection for N drivers of one tri-state bus,
//            with hold-limit rotation. Optional one-cycle bus turnaround
//            between owners when TRISTATE_ARB_TURNAROUND_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tristate_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         drv_en,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);

  localparam int         c_ow       = $clog2(N);
  localparam logic [7:0] c_hold_max = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_gnt;
  logic [N-1:0]    w_gnt_nxt;
  logic [c_ow-1:0] r_owner;
  logic [c_ow-1:0] w_owner_nxt;
  logic [7:0]      r_hold;
  logic [7:0]      w_hold_nxt;
  logic [7:0]      w_hold_inc;
  logic            w_hold_hit;
  logic [N-1:0]    w_own_oh;
  logic            w_own_req;
  logic            w_others;
  logic            w_any;
  logic [c_ow-1:0] w_rr_idx;
  logic [N-1:0]    w_rr_oh;
  int              w_dist;
  int              w_best;

  // Distance 0 is owner+1, distance N-1 is the owner itself, so the current
  // owner always loses to anyone else who is waiting.
  always_comb begin
    w_rr_idx = r_owner;
    w_rr_oh  = '0;
    w_best   = N;
    w_dist   = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i + N - 1 - int'(r_owner)) % N;
      if (req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_rr_idx = c_ow'(i);
      end
    end
    w_rr_oh[w_rr_idx] = |req;
  end

  always_comb begin
    w_own_oh          = '0;
    w_own_oh[r_owner] = 1'b1;
  end

  assign w_own_req  = |(req & w_own_oh);
  assign w_others   = |(req & ~w_own_oh);
  assign w_any      = |req;
  assign w_hold_inc = r_hold + 8'd1;
  assign w_hold_hit = (w_hold_inc == c_hold_max);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= c_ow'(N - 1);
      r_hold  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;
    case (r_state)
      S_IDLE, S_TURN: begin
        w_gnt_nxt  = '0;
        w_hold_nxt = 8'd0;
        if (w_any) begin
          w_state_nxt = S_OWN;
          w_owner_nxt = w_rr_idx;
          w_gnt_nxt   = w_rr_oh;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_OWN: begin
        w_hold_nxt = w_hold_inc;
        if (!w_own_req || (w_hold_hit && w_others)) begin
          w_hold_nxt = 8'd0;
`ifdef TRISTATE_ARB_TURNAROUND_EN
          w_state_nxt = S_TURN;
          w_gnt_nxt   = '0;
`else
          if (w_others) begin
            w_state_nxt = S_OWN;
            w_owner_nxt = w_rr_idx;
            w_gnt_nxt   = w_rr_oh;
          end else begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
          end
`endif
        end else if (w_hold_hit) begin
          // Nobody else is waiting: keep the bus and restart the hold window.
          w_hold_nxt = 8'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_hold_nxt  = 8'd0;
      end
    endcase
  end

  assign gnt    = r_gnt;
  assign drv_en = r_gnt;
  assign owner  = r_owner;
  assign busy   = |r_gnt;

endmodule
`default_nettype wire
